// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the SRAM port arbiter.
// Latency: none (types only). Backpressure: n/a.
// Optional RMW path in the top is enabled by SRAM_ARB_RMW_EN.
package sram_arb_pkg;
  localparam int unsigned SRAM_DATA_W = 32;
  localparam int unsigned SRAM_ADDR_W = 10;

  typedef enum logic {S_IDLE, S_RMW} state_e;
  typedef enum logic {OWN_IF, OWN_LS} owner_e;
endpackage

// File: rtl/sram_byte_merge.sv
// Per-byte select of store data over SRAM read data under byte enables.
// Latency: combinational. Backpressure: none.
module sram_byte_merge #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic [BE_WIDTH-1:0]   be,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] mdata
);
  always_comb begin
    mdata = rdata;
    for (int i = 0; i < int'(BE_WIDTH); i++) begin
      if (be[i]) mdata[i*8 +: 8] = wdata[i*8 +: 8];
    end
  end
endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between fetch and LSU; SRAM_ARB_RMW_EN adds sub-word RMW.
// Latency: read data / store completion one cycle after issue; RMW stores complete two cycles after issue.
// Backpressure: ready deasserts for the loser of arbitration and for both ports during the RMW write cycle.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SRAM_DATA_W,
  parameter int unsigned ADDR_WIDTH = SRAM_ADDR_W,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk0,
  input  logic                  rst,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_WIDTH-1:0] if_req_addr,
  output logic                  if_rsp_valid,
  output logic [DATA_WIDTH-1:0] if_rsp_rdata,
  input  logic                  ls_req_valid,
  output logic                  ls_req_ready,
  input  logic                  ls_req_we,
  input  logic [BE_WIDTH-1:0]   ls_req_be,
  input  logic [ADDR_WIDTH-1:0] ls_req_addr,
  input  logic [DATA_WIDTH-1:0] ls_req_wdata,
  output logic                  ls_rsp_valid,
  output logic [DATA_WIDTH-1:0] ls_rsp_rdata,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);
  owner_e last_gnt_q, last_gnt_d;
  owner_e pend_own_q, pend_own_d;
  logic   pend_vld_q, pend_vld_d;
  logic   gnt_if, gnt_ls;

`ifdef SRAM_ARB_RMW_EN
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rmw_addr_q, rmw_addr_d;
  logic [BE_WIDTH-1:0]   rmw_be_q, rmw_be_d;
  logic [DATA_WIDTH-1:0] rmw_wdata_q, rmw_wdata_d;
  logic [DATA_WIDTH-1:0] rmw_mdata;

  sram_byte_merge #(
    .DATA_WIDTH (DATA_WIDTH),
    .BE_WIDTH   (BE_WIDTH)
  ) u_merge (
    .be    (rmw_be_q),
    .wdata (rmw_wdata_q),
    .rdata (sram_dout),
    .mdata (rmw_mdata)
  );
`else
  logic unused_be;
  assign unused_be = ^ls_req_be;
`endif

  always_comb begin
    if_req_ready = 1'b0;
    ls_req_ready = 1'b0;
    sram_csb     = 1'b1;
    sram_web     = 1'b1;
    sram_addr    = '0;
    sram_din     = '0;
    gnt_if       = 1'b0;
    gnt_ls       = 1'b0;
    last_gnt_d   = last_gnt_q;
    pend_vld_d   = 1'b0;
    pend_own_d   = pend_own_q;
`ifdef SRAM_ARB_RMW_EN
    state_d      = state_q;
    rmw_addr_d   = rmw_addr_q;
    rmw_be_d     = rmw_be_q;
    rmw_wdata_d  = rmw_wdata_q;
`endif
    // Nothing reaches the macro while in reset, including an in-flight RMW write.
    if (!rst) begin
`ifdef SRAM_ARB_RMW_EN
      if (state_q == S_RMW) begin
        sram_csb   = 1'b0;
        sram_web   = 1'b0;
        sram_addr  = rmw_addr_q;
        sram_din   = rmw_mdata;
        pend_vld_d = 1'b1;
        pend_own_d = OWN_LS;
        state_d    = S_IDLE;
      end else
`endif
      begin
        gnt_if = if_req_valid && (!ls_req_valid || last_gnt_q == OWN_LS);
        gnt_ls = ls_req_valid && !gnt_if;
        if (gnt_if) begin
          if_req_ready = 1'b1;
          sram_csb     = 1'b0;
          sram_addr    = if_req_addr;
          last_gnt_d   = OWN_IF;
          pend_vld_d   = 1'b1;
          pend_own_d   = OWN_IF;
        end else if (gnt_ls) begin
          ls_req_ready = 1'b1;
          sram_csb     = 1'b0;
          sram_addr    = ls_req_addr;
          last_gnt_d   = OWN_LS;
          pend_vld_d   = 1'b1;
          pend_own_d   = OWN_LS;
          if (ls_req_we) begin
            sram_web = 1'b0;
            sram_din = ls_req_wdata;
`ifdef SRAM_ARB_RMW_EN
            // Sub-word store: read the old word now, write the merge next cycle.
            if (!(&ls_req_be)) begin
              sram_web    = 1'b1;
              sram_din    = '0;
              pend_vld_d  = 1'b0;
              rmw_addr_d  = ls_req_addr;
              rmw_be_d    = ls_req_be;
              rmw_wdata_d = ls_req_wdata;
              state_d     = S_RMW;
            end
`endif
          end
        end
      end
    end
  end

  always_ff @(posedge clk0) begin
    if (rst) begin
      last_gnt_q  <= OWN_LS;
      pend_vld_q  <= 1'b0;
      pend_own_q  <= OWN_IF;
`ifdef SRAM_ARB_RMW_EN
      state_q     <= S_IDLE;
      rmw_addr_q  <= '0;
      rmw_be_q    <= '0;
      rmw_wdata_q <= '0;
`endif
    end else begin
      last_gnt_q  <= last_gnt_d;
      pend_vld_q  <= pend_vld_d;
      pend_own_q  <= pend_own_d;
`ifdef SRAM_ARB_RMW_EN
      state_q     <= state_d;
      rmw_addr_q  <= rmw_addr_d;
      rmw_be_q    <= rmw_be_d;
      rmw_wdata_q <= rmw_wdata_d;
`endif
    end
  end

  assign if_rsp_valid = pend_vld_q && (pend_own_q == OWN_IF);
  assign ls_rsp_valid = pend_vld_q && (pend_own_q == OWN_LS);
  assign if_rsp_rdata = sram_dout;
  assign ls_rsp_rdata = sram_dout;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural 32x1024 SRAM model.
// Covers SRAM_ARB_RMW_EN builds and the default full-word-store build.
module tb_sram_port_arbiter;
  logic        clk0 = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [9:0]  if_req_addr;
  logic [31:0] if_rsp_rdata;
  logic        ls_req_valid, ls_req_ready, ls_req_we, ls_rsp_valid;
  logic [3:0]  ls_req_be;
  logic [9:0]  ls_req_addr;
  logic [31:0] ls_req_wdata, ls_rsp_rdata;
  logic        sram_csb, sram_web;
  logic [9:0]  sram_addr;
  logic [31:0] sram_din, sram_dout;

  logic [31:0] mem [0:1023];
  logic        pl_en;
  logic [9:0]  pl_addr;
  logic [31:0] pl_dat;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk0 = ~clk0;

  sram_port_arbiter dut (
    .clk0         (clk0),
    .rst          (rst),
    .if_req_valid (if_req_valid),
    .if_req_ready (if_req_ready),
    .if_req_addr  (if_req_addr),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_rdata (if_rsp_rdata),
    .ls_req_valid (ls_req_valid),
    .ls_req_ready (ls_req_ready),
    .ls_req_we    (ls_req_we),
    .ls_req_be    (ls_req_be),
    .ls_req_addr  (ls_req_addr),
    .ls_req_wdata (ls_req_wdata),
    .ls_rsp_valid (ls_rsp_valid),
    .ls_rsp_rdata (ls_rsp_rdata),
    .sram_csb     (sram_csb),
    .sram_web     (sram_web),
    .sram_addr    (sram_addr),
    .sram_din     (sram_din),
    .sram_dout    (sram_dout)
  );

  // Single-port macro model; preload port used only while the arbiter is in reset.
  always @(posedge clk0) begin
    if (pl_en) mem[pl_addr] <= pl_dat;
    else if (!sram_csb) begin
      if (!sram_web) mem[sram_addr] <= sram_din;
      else           sram_dout <= mem[sram_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic mid();
    @(negedge clk0);
  endtask

  initial begin
    rst = 1'b1;
    if_req_valid = 1'b0; if_req_addr = '0;
    ls_req_valid = 1'b0; ls_req_we = 1'b0; ls_req_be = '0;
    ls_req_addr = '0; ls_req_wdata = '0;
    pl_en = 1'b1; pl_addr = 10'h005; pl_dat = 32'hDEADBEEF;

    tick();
    pl_addr = 10'h020; pl_dat = 32'hAABBCCDD;
    mid();
    check_eq("rst_csb", sram_csb, 1);
    check_eq("rst_web", sram_web, 1);
    check_eq("rst_if_rsp", if_rsp_valid, 0);
    check_eq("rst_ls_rsp", ls_rsp_valid, 0);
    tick();
    pl_en = 1'b0; rst = 1'b0;

    // Lone fetch
    if_req_valid = 1'b1; if_req_addr = 10'h005;
    mid();
    check_eq("f_if_rdy", if_req_ready, 1);
    check_eq("f_ls_rdy", ls_req_ready, 0);
    check_eq("f_csb", sram_csb, 0);
    check_eq("f_web", sram_web, 1);
    check_eq("f_addr", sram_addr, 10'h005);
    tick();

    // Full-word store issued in the cycle the fetch response appears
    if_req_valid = 1'b0;
    ls_req_valid = 1'b1; ls_req_we = 1'b1; ls_req_be = 4'hF;
    ls_req_addr = 10'h010; ls_req_wdata = 32'h12345678;
    mid();
    check_eq("f_rsp_vld", if_rsp_valid, 1);
    check_eq("f_rsp_dat", if_rsp_rdata, 32'hDEADBEEF);
    check_eq("f_ls_rsp", ls_rsp_valid, 0);
    check_eq("st_rdy", ls_req_ready, 1);
    check_eq("st_web", sram_web, 0);
    check_eq("st_din", sram_din, 32'h12345678);
    tick();

    ls_req_we = 1'b0;
    mid();
    check_eq("st_rsp", ls_rsp_valid, 1);
    check_eq("ld_rdy", ls_req_ready, 1);
    check_eq("ld_web", sram_web, 1);
    check_eq("st_mem", mem[10'h010], 32'h12345678);
    tick();

    ls_req_valid = 1'b0;
    mid();
    check_eq("ld_rsp", ls_rsp_valid, 1);
    check_eq("ld_dat", ls_rsp_rdata, 32'h12345678);
    check_eq("ld_if_rsp", if_rsp_valid, 0);
    tick();

    // Both requesters valid for four cycles: IF, LS, IF, LS
    if_req_valid = 1'b1; if_req_addr = 10'h005;
    ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_addr = 10'h010;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) begin
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
      end
      mid();
      if (c < 4) begin
        check_eq($sformatf("rr_if_rdy%0d", c), if_req_ready, (c % 2 == 0));
        check_eq($sformatf("rr_ls_rdy%0d", c), ls_req_ready, (c % 2 == 1));
        check_eq($sformatf("rr_csb%0d", c), sram_csb, 0);
      end
      if (c > 0) begin
        check_eq($sformatf("rr_if_rsp%0d", c), if_rsp_valid, ((c - 1) % 2 == 0));
        check_eq($sformatf("rr_ls_rsp%0d", c), ls_rsp_valid, ((c - 1) % 2 == 1));
        if ((c - 1) % 2 == 0) check_eq($sformatf("rr_if_dat%0d", c), if_rsp_rdata, 32'hDEADBEEF);
        else                  check_eq($sformatf("rr_ls_dat%0d", c), ls_rsp_rdata, 32'h12345678);
      end
      tick();
    end

    // Partial store to 0x020, issued at T
    ls_req_valid = 1'b1; ls_req_we = 1'b1; ls_req_be = 4'b0010;
    ls_req_addr = 10'h020; ls_req_wdata = 32'h00001100;
    mid();
    check_eq("ps_rdy", ls_req_ready, 1);
    check_eq("ps_csb", sram_csb, 0);
`ifdef SRAM_ARB_RMW_EN
    check_eq("ps_rd_web", sram_web, 1);
    tick();
    // T+1: write of merged word; a fetch and a load wait
    ls_req_we = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 10'h005;
    mid();
    check_eq("rmw_if_rdy", if_req_ready, 0);
    check_eq("rmw_ls_rdy", ls_req_ready, 0);
    check_eq("rmw_csb", sram_csb, 0);
    check_eq("rmw_web", sram_web, 0);
    check_eq("rmw_addr", sram_addr, 10'h020);
    check_eq("rmw_din", sram_din, 32'hAABB11DD);
    check_eq("rmw_ls_rsp", ls_rsp_valid, 0);
    tick();
    mid();
    check_eq("rmw_done", ls_rsp_valid, 1);
    check_eq("rmw_if_gnt", if_req_ready, 1);
    check_eq("rmw_ls_wait", ls_req_ready, 0);
    tick();
    if_req_valid = 1'b0;
    mid();
    check_eq("rmw_if_rsp", if_rsp_valid, 1);
    check_eq("rmw_if_dat", if_rsp_rdata, 32'hDEADBEEF);
    check_eq("rmw_ld_rdy", ls_req_ready, 1);
    tick();
    ls_req_valid = 1'b0;
    mid();
    check_eq("rmw_ld_rsp", ls_rsp_valid, 1);
    check_eq("rmw_ld_dat", ls_rsp_rdata, 32'hAABB11DD);
    check_eq("rmw_mem", mem[10'h020], 32'hAABB11DD);
    tick();

    // Reset while in the RMW write cycle
    ls_req_valid = 1'b1; ls_req_we = 1'b1; ls_req_be = 4'b0001;
    ls_req_addr = 10'h020; ls_req_wdata = 32'h000000FF;
    mid();
    check_eq("rr_ps_rdy", ls_req_ready, 1);
    check_eq("rr_ps_web", sram_web, 1);
    tick();
    rst = 1'b1; ls_req_valid = 1'b0;
    mid();
    check_eq("rr_csb", sram_csb, 1);
    tick();
    rst = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 10'h005;
    mid();
    check_eq("rr_ls_rsp", ls_rsp_valid, 0);
    check_eq("rr_if_rsp", if_rsp_valid, 0);
    check_eq("rr_mem", mem[10'h020], 32'hAABB11DD);
    check_eq("rr_idle_gnt", if_req_ready, 1);
    tick();
    if_req_valid = 1'b0;
    mid();
    check_eq("rr_if_after", if_rsp_valid, 1);
    tick();
`else
    check_eq("ps_web", sram_web, 0);
    check_eq("ps_din", sram_din, 32'h00001100);
    tick();
    ls_req_valid = 1'b0;
    mid();
    check_eq("ps_rsp", ls_rsp_valid, 1);
    check_eq("ps_mem", mem[10'h020], 32'h00001100);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
